// File: rtl/fau_seq_pkg.sv
// fau_seq_pkg: shared types for the field-arithmetic-unit sequencer.
//   fau_op_e    - command opcode (ADD/SUB/MULT/NOP)
//   fau_state_e - sequencer FSM states
//   cnt_width() - width of the shared latency/guard down-counter
package fau_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MULT = 2'b10,
    OP_NOP  = 2'b11
  } fau_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StAddWait,
    StMultGuard,
    StMultWait,
    StResp
  } fau_state_e;

  // The counter is loaded with (latency - 1), so it must hold max(a, b) - 1.
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/fau_seq_cnt.sv
// fau_seq_cnt: loadable down-counter with zero flag. Shared by the
// add-latency wait and the multiplier start guard.
//   clk, reset_n - clock, async active-low reset
//   load         - load load_val (wins over dec)
//   load_val     - value to load
//   dec          - decrement by one, saturating at zero
//   zero         - counter value is zero
module fau_seq_cnt #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/fau_seq.sv
// fau_seq: serialises field-operation commands into one field arithmetic unit
// (modular add/sub + Montgomery multiplier) and returns the selected result.
//   clk, reset_n       - clock, async active-low reset
//   cmd_*              - valid/ready command: op, red, opa, opb
//   rsp_*              - valid/ready response: data, err (watchdog abort)
//   fau_sub/red_o      - adder controls, held through the add wait
//   fau_mult_start_o   - held high from issue until the multiplier reports ready
//   fau_opa/opb_o      - registered operands, stable until the response handshake
//   fau_add_res_i, fau_mult_res_i, fau_mult_ready_i - results from the unit
// Optional macro FAU_SEQ_TIMEOUT_EN builds a watchdog that aborts a stuck
// operation after TIMEOUT_CYC wait cycles with rsp_err_o = 1 and zero data.
module fau_seq
  import fau_seq_pkg::*;
#(
  parameter int unsigned REG_SIZE    = 384,
  parameter int unsigned ADD_LAT     = 2,
  parameter int unsigned MULT_GUARD  = 3,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_op_i,
  input  logic                cmd_red_i,
  input  logic [REG_SIZE-1:0] cmd_opa_i,
  input  logic [REG_SIZE-1:0] cmd_opb_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [REG_SIZE-1:0] rsp_data_o,
  output logic                rsp_err_o,
  output logic                fau_sub_o,
  output logic                fau_red_o,
  output logic                fau_mult_start_o,
  output logic [REG_SIZE-1:0] fau_opa_o,
  output logic [REG_SIZE-1:0] fau_opb_o,
  input  logic [REG_SIZE-1:0] fau_add_res_i,
  input  logic [REG_SIZE-1:0] fau_mult_res_i,
  input  logic                fau_mult_ready_i
);

  localparam int unsigned      CNT_W      = cnt_width(ADD_LAT, MULT_GUARD);
  localparam logic [CNT_W-1:0] ADD_LOAD   = CNT_W'(ADD_LAT - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(MULT_GUARD - 1);

  fau_state_e          state_q, state_d;
  fau_op_e             op_q;
  logic                red_q;
  logic [REG_SIZE-1:0] opa_q, opb_q;
  logic [REG_SIZE-1:0] data_q, data_d;
  logic                accept;
  logic                cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]    cnt_load_val;
  logic                timeout;

  assign cmd_ready_o = (state_q == StIdle);
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_data_o  = data_q;
  assign fau_opa_o   = opa_q;
  assign fau_opb_o   = opb_q;

  fau_seq_cnt #(
    .WIDTH(CNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  // Next state and response capture.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    cnt_load     = 1'b0;
    cnt_load_val = ADD_LOAD;
    cnt_dec      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (cmd_op_i == OP_NOP) begin
            data_d  = '0;
            state_d = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_load = 1'b1;
        if (op_q == OP_MULT) begin
          cnt_load_val = GUARD_LOAD;
          state_d      = StMultGuard;
        end else begin
          cnt_load_val = ADD_LOAD;
          state_d      = StAddWait;
        end
      end
      StAddWait: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          data_d  = fau_add_res_i;
          state_d = StResp;
        end
      end
      StMultGuard: begin
        // mult_ready still reflects the previous operation here.
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = StMultWait;
        end
      end
      StMultWait: begin
        if (fau_mult_ready_i) begin
          data_d  = fau_mult_res_i;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (timeout) begin
      data_d  = '0;
      state_d = StResp;
    end
  end

  // Unit controls decode purely from state so they drop with the async reset.
  always_comb begin
    fau_sub_o        = 1'b0;
    fau_red_o        = 1'b0;
    fau_mult_start_o = 1'b0;
    unique case (state_q)
      StIssue: begin
        if (op_q == OP_MULT) begin
          fau_mult_start_o = 1'b1;
        end else begin
          fau_sub_o = (op_q == OP_SUB);
          fau_red_o = red_q;
        end
      end
      StAddWait: begin
        fau_sub_o = (op_q == OP_SUB);
        fau_red_o = red_q;
      end
      StMultGuard, StMultWait: fau_mult_start_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      op_q    <= OP_ADD;
      red_q   <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      if (accept) begin
        op_q  <= fau_op_e'(cmd_op_i);
        red_q <= cmd_red_i;
        opa_q <= cmd_opa_i;
        opb_q <= cmd_opb_i;
      end
    end
  end

`ifdef FAU_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            in_wait;
  logic            err_q;

  assign in_wait = (state_q == StAddWait) || (state_q == StMultGuard) ||
                   (state_q == StMultWait);
  assign timeout = in_wait && (to_cnt_q == TO_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        to_cnt_q <= '0;
      end else if (in_wait && !timeout) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
      if (timeout) begin
        err_q <= 1'b1;
      end else if (rsp_valid_o && rsp_ready_i) begin
        err_q <= 1'b0;
      end
    end
  end

  assign rsp_err_o = err_q;
`else
  assign timeout   = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fau_seq.sv
// tb_fau_seq: directed self-checking bench for fau_seq. Models the field
// arithmetic unit's adder as a two-stage pipeline and drives the multiplier
// handshake directly from the scenario tasks.
module tb_fau_seq;
  import fau_seq_pkg::*;

  localparam int unsigned W           = 384;
  localparam int unsigned TIMEOUT_CYC = 1023;
  localparam logic [W-1:0] PRIME = {W{1'b1}} - (W'(1) << 128) - (W'(1) << 96) + (W'(1) << 32);

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cmd_valid, cmd_ready, cmd_red;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_opa, cmd_opb;
  logic         rsp_valid, rsp_ready, rsp_err;
  logic [W-1:0] rsp_data;
  logic         fau_sub, fau_red, fau_mult_start, fau_mult_ready;
  logic [W-1:0] fau_opa, fau_opb, fau_add_res, fau_mult_res;
  logic [W-1:0] add_stage;

  int checks = 0;
  int fails  = 0;
  int start_rises = 0;

  always #5 clk = ~clk;

  fau_seq #(
    .REG_SIZE   (W),
    .ADD_LAT    (2),
    .MULT_GUARD (3),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cmd_valid_i     (cmd_valid),
    .cmd_ready_o     (cmd_ready),
    .cmd_op_i        (cmd_op),
    .cmd_red_i       (cmd_red),
    .cmd_opa_i       (cmd_opa),
    .cmd_opb_i       (cmd_opb),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_data_o      (rsp_data),
    .rsp_err_o       (rsp_err),
    .fau_sub_o       (fau_sub),
    .fau_red_o       (fau_red),
    .fau_mult_start_o(fau_mult_start),
    .fau_opa_o       (fau_opa),
    .fau_opb_o       (fau_opb),
    .fau_add_res_i   (fau_add_res),
    .fau_mult_res_i  (fau_mult_res),
    .fau_mult_ready_i(fau_mult_ready)
  );

  // Adder model of the unit: modular add/sub, result two cycles after the controls.
  function automatic logic [W-1:0] add_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sub, input logic red);
    logic [W:0] s;
    if (sub) begin
      s = {1'b0, a} - {1'b0, b};
      if (red && (a < b)) s = s + {1'b0, PRIME};
    end else begin
      s = {1'b0, a} + {1'b0, b};
      if (red && (s >= {1'b0, PRIME})) s = s - {1'b0, PRIME};
    end
    return s[W-1:0];
  endfunction

  always @(posedge clk) begin
    add_stage   <= add_model(fau_opa, fau_opb, fau_sub, fau_red);
    fau_add_res <= add_stage;
  end

  always @(posedge fau_mult_start) start_rises = start_rises + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "bench watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic red, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    int n;
    cmd_op = op; cmd_red = red; cmd_opa = a; cmd_opb = b; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++; fails++;
      $display("FAIL cmd_accept: cmd_ready stayed 0 for %0d cycles", n);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  // Returns cycles from accept to rsp_valid and how often the unit controls
  // differed from their value in the cycle after accept.
  task automatic wait_rsp(input int budget, output int lat, output int ctl_changes);
    logic [2:0] ctl0;
    bit done;
    ctl0 = {fau_sub, fau_red, fau_mult_start};
    ctl_changes = 0; lat = -1; done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      if (rsp_valid) begin
        lat = i + 1;
        done = 1;
      end else begin
        if ({fau_sub, fau_red, fau_mult_start} !== ctl0) ctl_changes++;
        tick();
      end
    end
    if (!done) begin
      checks++; fails++;
      $display("FAIL rsp_wait: no rsp_valid within %0d cycles", budget);
    end
  endtask

  task automatic finish_rsp(input string name);
    rsp_ready = 1'b1;
    tick();
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      fails++;
      $display("FAIL %s_handshake: {rsp_valid,cmd_ready}=%b, want 01", name,
               {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_red = 1'b0;
    cmd_opa = '0; cmd_opb = '0; rsp_ready = 1'b1;
    fau_mult_ready = 1'b0; fau_mult_res = '0;
    repeat (3) tick();
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, fau_sub, fau_red, fau_mult_start} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_ctl: got %b, want 100000",
               {cmd_ready, rsp_valid, rsp_err, fau_sub, fau_red, fau_mult_start});
    end
    #2 reset_n = 1'b1;
    tick();
    checks++;
    if ((rsp_data !== '0) || (fau_opa !== '0) || (fau_opb !== '0) || (cmd_ready !== 1'b1)) begin
      fails++;
      $display("FAIL reset_data: rsp_data=%0h opa=%0h opb=%0h cmd_ready=%b, want 0 0 0 1",
               rsp_data, fau_opa, fau_opb, cmd_ready);
    end
  endtask

  task automatic test_add_sub();
    logic [1:0]   v_op[5];
    logic         v_red[5];
    logic [W-1:0] v_a[5], v_b[5], v_exp[5];
    logic [1:0]   v_ctl[5];
    int lat, chg;
    v_op[0] = OP_ADD; v_red[0] = 1; v_a[0] = 5;         v_b[0] = 7; v_exp[0] = 12;
    v_ctl[0] = 2'b01;
    v_op[1] = OP_SUB; v_red[1] = 1; v_a[1] = 3;         v_b[1] = 5; v_exp[1] = PRIME - W'(2);
    v_ctl[1] = 2'b11;
    v_op[2] = OP_ADD; v_red[2] = 1; v_a[2] = PRIME - 1; v_b[2] = 2; v_exp[2] = 1;
    v_ctl[2] = 2'b01;
    v_op[3] = OP_ADD; v_red[3] = 0; v_a[3] = PRIME - 1; v_b[3] = 2; v_exp[3] = PRIME + W'(1);
    v_ctl[3] = 2'b00;
    v_op[4] = OP_SUB; v_red[4] = 0; v_a[4] = 3;         v_b[4] = 5; v_exp[4] = {W{1'b1}} - W'(1);
    v_ctl[4] = 2'b10;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send_cmd(v_op[k], v_red[k], v_a[k], v_b[k]);
      checks++;
      if ({fau_sub, fau_red, fau_mult_start} !== {v_ctl[k], 1'b0}) begin
        fails++;
        $display("FAIL addsub%0d_ctl: {sub,red,start}=%b, want %b", k,
                 {fau_sub, fau_red, fau_mult_start}, {v_ctl[k], 1'b0});
      end
      checks++;
      if ((fau_opa !== v_a[k]) || (fau_opb !== v_b[k])) begin
        fails++;
        $display("FAIL addsub%0d_operands: opa=%0h opb=%0h, want %0h %0h", k, fau_opa, fau_opb,
                 v_a[k], v_b[k]);
      end
      wait_rsp(20, lat, chg);
      checks++;
      if (lat !== 4) begin
        fails++;
        $display("FAIL addsub%0d_latency: got %0d, want 4", k, lat);
      end
      checks++;
      if (chg !== 0) begin
        fails++;
        $display("FAIL addsub%0d_ctl_hold: controls changed %0d times, want 0", k, chg);
      end
      checks++;
      if (rsp_data !== v_exp[k]) begin
        fails++;
        $display("FAIL addsub%0d_data: got %0h, want %0h", k, rsp_data, v_exp[k]);
      end
      checks++;
      if ({fau_sub, fau_red, fau_mult_start, rsp_err} !== 4'b0000) begin
        fails++;
        $display("FAIL addsub%0d_resp_ctl: {sub,red,start,err}=%b, want 0000", k,
                 {fau_sub, fau_red, fau_mult_start, rsp_err});
      end
      finish_rsp("addsub");
    end
  endtask

  task automatic test_nop();
    int lat, chg;
    rsp_ready = 1'b1;
    send_cmd(OP_NOP, 1'b1, W'(32'habc), W'(32'h123));
    wait_rsp(5, lat, chg);
    checks++;
    if (lat !== 1) begin
      fails++;
      $display("FAIL nop_latency: got %0d, want 1", lat);
    end
    checks++;
    if ((rsp_data !== '0) || ({fau_sub, fau_red, fau_mult_start} !== 3'b000)) begin
      fails++;
      $display("FAIL nop_data: data=%0h ctl=%b, want 0 000", rsp_data,
               {fau_sub, fau_red, fau_mult_start});
    end
    finish_rsp("nop");
  endtask

  task automatic test_mult_forced();
    logic [W-1:0] v1;
    int lat, chg;
    v1 = {12{32'h0123_4567}};
    fau_mult_ready = 1'b1; fau_mult_res = v1; rsp_ready = 1'b1;
    start_rises = 0;
    send_cmd(OP_MULT, 1'b0, W'(11), W'(13));
    checks++;
    if ({fau_sub, fau_red, fau_mult_start} !== 3'b001) begin
      fails++;
      $display("FAIL mult_issue_ctl: {sub,red,start}=%b, want 001",
               {fau_sub, fau_red, fau_mult_start});
    end
    wait_rsp(50, lat, chg);
    checks++;
    if (lat !== 6) begin
      fails++;
      $display("FAIL mult_guard_latency: got %0d, want 6", lat);
    end
    checks++;
    if (chg !== 0) begin
      fails++;
      $display("FAIL mult_start_hold: start changed %0d times, want 0", chg);
    end
    checks++;
    if ((rsp_data !== v1) || (fau_mult_start !== 1'b0) || (start_rises !== 1)) begin
      fails++;
      $display("FAIL mult_forced_result: data=%0h start=%b rises=%0d, want %0h 0 1", rsp_data,
               fau_mult_start, start_rises, v1);
    end
    finish_rsp("mult_forced");
  endtask

  task automatic test_mult_slow();
    logic [W-1:0] v2, junk;
    int early, low;
    v2 = {6{64'hfeed_face_cafe_beef}};
    junk = {12{32'h5a5a_5a5a}};
    fau_mult_ready = 1'b1; fau_mult_res = junk; rsp_ready = 1'b1;
    start_rises = 0; early = 0; low = 0;
    send_cmd(OP_MULT, 1'b0, W'(17), W'(19));
    tick();
    fau_mult_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) early++;
      if (!fau_mult_start) low++;
      tick();
    end
    fau_mult_ready = 1'b1; fau_mult_res = v2;
    tick();
    checks++;
    if ((early !== 0) || (low !== 0)) begin
      fails++;
      $display("FAIL mult_slow_wait: early_valid=%0d start_low=%0d, want 0 0", early, low);
    end
    checks++;
    if ((rsp_valid !== 1'b1) || (rsp_data !== v2)) begin
      fails++;
      $display("FAIL mult_slow_capture: valid=%b data=%0h, want 1 %0h", rsp_valid, rsp_data, v2);
    end
    fau_mult_res = junk;
    checks++;
    if (start_rises !== 1) begin
      fails++;
      $display("FAIL mult_slow_edges: got %0d start edges, want 1", start_rises);
    end
    finish_rsp("mult_slow");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] v3, v4, a1, a2;
    int lat, chg, bad, rdy;
    v3 = {12{32'h3333_1111}}; v4 = {12{32'h4444_2222}};
    a1 = W'(101); a2 = W'(202);
    fau_mult_ready = 1'b1; fau_mult_res = v3; rsp_ready = 1'b0;
    start_rises = 0; bad = 0; rdy = 0;
    send_cmd(OP_MULT, 1'b0, a1, W'(7));
    wait_rsp(50, lat, chg);
    checks++;
    if (lat !== 6) begin
      fails++;
      $display("FAIL b2b_first_latency: got %0d, want 6", lat);
    end
    cmd_op = OP_MULT; cmd_red = 1'b0; cmd_opa = a2; cmd_opb = W'(9); cmd_valid = 1'b1;
    fau_mult_res = v4;
    for (int i = 0; i < 10; i++) begin
      if ((rsp_valid !== 1'b1) || (rsp_data !== v3) || (fau_opa !== a1)) bad++;
      if (cmd_ready !== 1'b0) rdy++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL b2b_stall_stable: %0d unstable cycles, want 0", bad);
    end
    checks++;
    if (rdy !== 0) begin
      fails++;
      $display("FAIL b2b_stall_cmd_ready: cmd_ready high %0d cycles, want 0", rdy);
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if ({cmd_ready, fau_mult_start, rsp_valid} !== 3'b100) begin
      fails++;
      $display("FAIL b2b_gap: {cmd_ready,start,rsp_valid}=%b, want 100",
               {cmd_ready, fau_mult_start, rsp_valid});
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ((fau_opa !== a2) || (fau_mult_start !== 1'b1)) begin
      fails++;
      $display("FAIL b2b_second_issue: opa=%0h start=%b, want %0h 1", fau_opa, fau_mult_start, a2);
    end
    wait_rsp(50, lat, chg);
    checks++;
    if ((lat !== 6) || (rsp_data !== v4) || (start_rises !== 2)) begin
      fails++;
      $display("FAIL b2b_second_result: lat=%0d data=%0h rises=%0d, want 6 %0h 2", lat, rsp_data,
               start_rises, v4);
    end
    finish_rsp("b2b");
  endtask

  task automatic test_reset_mid();
    int lat, chg, seen;
    fau_mult_ready = 1'b1; fau_mult_res = {12{32'h7777_7777}}; rsp_ready = 1'b1;
    send_cmd(OP_MULT, 1'b0, W'(23), W'(29));
    tick();
    fau_mult_ready = 1'b0;
    repeat (6) tick();
    checks++;
    if ({fau_mult_start, rsp_valid, cmd_ready} !== 3'b100) begin
      fails++;
      $display("FAIL rstmid_pre: {start,rsp_valid,cmd_ready}=%b, want 100",
               {fau_mult_start, rsp_valid, cmd_ready});
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (({cmd_ready, rsp_valid, rsp_err, fau_sub, fau_red, fau_mult_start} !== 6'b100000) ||
        (fau_opa !== '0) || (rsp_data !== '0)) begin
      fails++;
      $display("FAIL rstmid_async: ctl=%b opa=%0h data=%0h, want 100000 0 0",
               {cmd_ready, rsp_valid, rsp_err, fau_sub, fau_red, fau_mult_start}, fau_opa,
               rsp_data);
    end
    #2 reset_n = 1'b1;
    tick();
    seen = 0;
    fau_mult_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL rstmid_no_rsp: rsp_valid high %0d cycles, want 0", seen);
    end
    send_cmd(OP_ADD, 1'b0, W'(10), W'(20));
    wait_rsp(20, lat, chg);
    checks++;
    if ((lat !== 4) || (rsp_data !== W'(30))) begin
      fails++;
      $display("FAIL rstmid_add_after: lat=%0d data=%0h, want 4 1e", lat, rsp_data);
    end
    finish_rsp("rstmid");
  endtask

`ifdef FAU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int lat, chg;
    fau_mult_ready = 1'b0; fau_mult_res = {12{32'h9999_9999}}; rsp_ready = 1'b0;
    send_cmd(OP_MULT, 1'b0, W'(31), W'(37));
    wait_rsp(TIMEOUT_CYC + 40, lat, chg);
    checks++;
    if ((lat < int'(TIMEOUT_CYC)) || (lat > int'(TIMEOUT_CYC) + 6)) begin
      fails++;
      $display("FAIL timeout_latency: got %0d, want about %0d", lat, TIMEOUT_CYC);
    end
    checks++;
    if ((rsp_err !== 1'b1) || (rsp_data !== '0) || (fau_mult_start !== 1'b0)) begin
      fails++;
      $display("FAIL timeout_resp: err=%b data=%0h start=%b, want 1 0 0", rsp_err, rsp_data,
               fau_mult_start);
    end
    finish_rsp("timeout");
    checks++;
    if (rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_err_clear: err=%b, want 0", rsp_err);
    end
    fau_mult_ready = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_add_sub();
    test_nop();
    test_mult_forced();
    test_mult_slow();
    test_back_to_back();
    test_reset_mid();
`ifdef FAU_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
